nf_mem_arbiter: RTL
===================

Name: nf_mem_arbiter

Overview:
- Arbitrates and sequences one shared single-port memory bus between the instruction fetch port (I) and the load/store port (D) of the core.
- D has fixed priority over I, with an anti-starvation limit that guarantees I a grant after MAX_D_RUN consecutive contended D grants.
- Every transaction runs through a registered state machine with a bus timeout, so a hung slave cannot lock the pipeline.

Parameters:
- MAX_D_RUN, 4, consecutive D grants allowed while i_req is pending before I is forced a grant (1..15).
- TIMEOUT, 255, cycles in BUSY without m_ack before the transaction is terminated with an error (1..65535).

Ports:
- clk  in  1  system clock, all state updates on its rising edge
- resetn  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request, held with i_addr until i_ack
- i_addr  in  32  instruction address
- i_rd  out  32  instruction read data, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for I
- d_req  in  1  data request, held with d_we/d_addr/d_wd until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wd  in  32  write data
- d_rd  out  32  data read data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse for D
- m_req  out  1  memory bus request, registered
- m_we  out  1  memory write enable, registered
- m_addr  out  32  memory address, registered
- m_wd  out  32  memory write data, registered
- m_rd  in  32  memory read data, valid with m_ack
- m_ack  in  1  memory completion, sampled only in BUSY
- bus_err  out  1  one-cycle pulse coincident with the i_ack/d_ack of a timed-out transaction

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; d_run=0; timeout counter=0.
  - All outputs are 0, including i_rd, d_rd, m_addr and m_wd.
  - An in-flight transaction is abandoned and no ack is issued.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If neither request is high, remain in IDLE with m_req=0.
  - Grant D if d_req=1 and not (i_req=1 and d_run==MAX_D_RUN).
  - Otherwise grant I if i_req=1.
  - On a grant: register m_req=1 and the granted master's address, plus we/wd for D (m_we=0, m_wd=0 for I). Latch owner and go to BUSY.
- d_run update on a grant:
  - D granted with i_req=1: d_run+1.
  - D granted with i_req=0: d_run=0.
  - I granted: d_run=0.
- BUSY:
  - m_req and m_addr/m_we/m_wd are held stable.
  - The timeout counter increments every cycle that m_ack=0.
  - m_ack=1: capture m_rd into the owner's rd register (reads only; writes return 0). m_req→0 and go to RESP.
  - Counter reaching TIMEOUT with m_ack=0: rd=0, set the error flag, m_req→0, go to RESP.
  - m_ack arriving on the same cycle as the counter reaching TIMEOUT: the transaction completes normally, with no error.
- RESP (exactly one cycle):
  - The owner's ack=1 and bus_err=error flag.
  - The other master's ack stays 0.
  - Clear the counter and the error flag, then go to IDLE.
  - Requests are ignored in RESP, so a master that keeps req high after its ack is re-arbitrated in the following IDLE cycle.
- Latency:
  - Request seen in IDLE at cycle N gives m_req=1 at N+1.
  - m_ack at cycle N+k (k≥1) gives x_ack at N+k+1.
  - Minimum transaction occupancy is 3 cycles (IDLE, BUSY, RESP).
- m_ack outside BUSY is ignored.
- rd registers hold their last value outside ack, but they are defined only while ack=1.
- A requester dropping req before its ack (protocol violation) does not cancel the transaction; the ack is still issued.

Test Plan:
- Reset then single I read:
  - Stimulus: i_req=1, i_addr=0x0000_0010; memory acks one cycle after m_req with m_rd=0x0051_3023.
  - Required: m_req rises 1 cycle after sampling, m_addr=0x10, m_we=0, and i_ack one cycle later with i_rd=0x0051_3023.
  - d_ack and bus_err stay 0.
- Simultaneous requests:
  - Stimulus: d_req (write, d_addr=0x100, d_wd=0xDEADBEEF) and i_req both high.
  - Required: D is granted first with m_we=1, m_wd=0xDEADBEEF, and d_ack gives d_rd=0. I is then served in the next IDLE.
- Starvation limit:
  - Stimulus: d_req and i_req held high continuously (default MAX_D_RUN=4).
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I.
- Timeout:
  - Stimulus: TIMEOUT=8; D read with m_ack never asserted.
  - Required: after 8 BUSY cycles, m_req drops and d_ack=1 with bus_err=1 and d_rd=0. A following I read completes normally with bus_err=0.
- Reset mid-operation:
  - Stimulus: resetn=0 asynchronously while in BUSY.
  - Required: m_req and all outputs go to 0 immediately, and no ack is issued after release.
  - The first request after release is granted with d_run=0.
- Stray and boundary m_ack:
  - Stimulus: m_ack pulsed in IDLE.
  - Required: no ack and no state change.
  - Stimulus: m_ack on the exact TIMEOUT cycle.
  - Required: normal completion with captured m_rd and bus_err=0.

Source files
------------

// File: rtl/nf_mem_arbiter_if.sv
// Shared memory arbiter bundle: I fetch port, D load/store
// port and the single-port memory bus, seen from either side.
interface nf_mem_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rd;
   logic        i_ack;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wd;
   logic [31:0] d_rd;
   logic        d_ack;

   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wd;
   logic [31:0] m_rd;
   logic        m_ack;

   logic        bus_err;

   modport slave (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wd,
      input  m_rd, m_ack,
      output i_rd, i_ack,
      output d_rd, d_ack,
      output m_req, m_we, m_addr, m_wd,
      output bus_err
   );

   modport master (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wd,
      output m_rd, m_ack,
      input  i_rd, i_ack,
      input  d_rd, d_ack,
      input  m_req, m_we, m_addr, m_wd,
      input  bus_err
   );

endinterface

// File: rtl/nf_mem_arbiter.sv
// I/D arbiter for one single-port memory bus: D priority with
// an I anti-starvation limit and a BUSY timeout.
module nf_mem_arbiter #(
   parameter int unsigned MAX_D_RUN = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic            clk,
   input  logic            resetn,
   nf_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   localparam logic [3:0]  RUN_MAX = 4'(MAX_D_RUN);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_n;
   logic        owner_d, owner_d_n;
   logic [3:0]  d_run, d_run_n;
   logic [15:0] cnt, cnt_n;
   logic        err, err_n;
   logic        m_req, m_req_n;
   logic        m_we, m_we_n;
   logic [31:0] m_addr, m_addr_n;
   logic [31:0] m_wd, m_wd_n;
   logic [31:0] i_rd, i_rd_n;
   logic [31:0] d_rd, d_rd_n;
   logic        gnt_d, gnt_i;
   logic [31:0] rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         owner_d <= 1'b0;
         d_run   <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wd    <= '0;
         i_rd    <= '0;
         d_rd    <= '0;
      end else begin
         state   <= state_n;
         owner_d <= owner_d_n;
         d_run   <= d_run_n;
         cnt     <= cnt_n;
         err     <= err_n;
         m_req   <= m_req_n;
         m_we    <= m_we_n;
         m_addr  <= m_addr_n;
         m_wd    <= m_wd_n;
         i_rd    <= i_rd_n;
         d_rd    <= d_rd_n;
      end
   end

   always_comb begin
      state_n   = state;
      owner_d_n = owner_d;
      d_run_n   = d_run;
      cnt_n     = cnt;
      err_n     = err;
      m_req_n   = m_req;
      m_we_n    = m_we;
      m_addr_n  = m_addr;
      m_wd_n    = m_wd;
      i_rd_n    = i_rd;
      d_rd_n    = d_rd;
      gnt_d     = 1'b0;
      gnt_i     = 1'b0;
      rdata     = '0;
      unique case (state)
         IDLE: begin
            gnt_d = bus.d_req &&
                    !(bus.i_req && d_run == RUN_MAX);
            gnt_i = !gnt_d && bus.i_req;
            if (gnt_d) begin
               owner_d_n = 1'b1;
               m_req_n   = 1'b1;
               m_we_n    = bus.d_we;
               m_addr_n  = bus.d_addr;
               m_wd_n    = bus.d_wd;
               d_run_n   = bus.i_req ? d_run + 4'd1 : 4'd0;
               state_n   = BUSY;
            end else if (gnt_i) begin
               owner_d_n = 1'b0;
               m_req_n   = 1'b1;
               m_we_n    = 1'b0;
               m_addr_n  = bus.i_addr;
               m_wd_n    = '0;
               d_run_n   = '0;
               state_n   = BUSY;
            end
         end
         BUSY: begin
            // m_ack wins over a timeout landing on the same cycle
            if (bus.m_ack) begin
               rdata   = m_we ? 32'h0 : bus.m_rd;
               m_req_n = 1'b0;
               state_n = RESP;
               if (owner_d) d_rd_n = rdata;
               else         i_rd_n = rdata;
            end else if (cnt == TO_LAST) begin
               cnt_n   = cnt + 16'd1;
               err_n   = 1'b1;
               m_req_n = 1'b0;
               state_n = RESP;
               if (owner_d) d_rd_n = '0;
               else         i_rd_n = '0;
            end else begin
               cnt_n = cnt + 16'd1;
            end
         end
         RESP: begin
            cnt_n   = '0;
            err_n   = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.i_ack   = (state == RESP) && !owner_d;
   assign bus.d_ack   = (state == RESP) && owner_d;
   assign bus.bus_err = (state == RESP) && err;
   assign bus.i_rd    = i_rd;
   assign bus.d_rd    = d_rd;
   assign bus.m_req   = m_req;
   assign bus.m_we    = m_we;
   assign bus.m_addr  = m_addr;
   assign bus.m_wd    = m_wd;

endmodule
